mod_n_counter: RTL and testbench
================================

Name: mod_n_counter

Overview:
- Parametrised synchronous modulo-N up/down counter. It is the successor to the team's fixed 4-bit binary counter.
- Adds configurable width and modulus, count direction, wrap or stop mode, and a registered wrap pulse.
- Used as the seconds, minutes and hours building block of the clock datapath. It cascades through CTT/CO the same way the existing counters do.

Parameters:
- WIDTH, 4, counter width in bits; 1 <= WIDTH <= 16.
- MODULUS, 16, count range 0..MODULUS-1; 2 <= MODULUS <= 2**WIDTH. An elaboration-time check fails on violation.
- STOP_MODE, 0, 0 = wrap at terminal count; 1 = hold at terminal count (one-shot/timer use).
- RST_VAL, 0, value loaded by reset; must be < MODULUS.

Ports:
- CP  input  1  clock; all state changes on the rising edge.
- CR  input  1  reset. One clock; reset is synchronous and active-high.
- Ld  input  1  synchronous parallel load, active-high.
- D  input  WIDTH  load value.
- CTT  input  1  count enable; also gates CO (cascade enable).
- CTP  input  1  count enable.
- UD  input  1  direction: 1 = up, 0 = down.
- Q  output  WIDTH  registered count.
- CO  output  1  combinational terminal-count / ripple carry.
- WRP  output  1  registered one-cycle pulse: a wrap or stop-hit occurred on the previous edge.

Behaviour:
- Priority on each rising CP edge: CR > Ld > count > hold.
- CR=1 -> Q<=RST_VAL, WRP<=0, regardless of Ld/CTT/CTP. Reset mid-count discards the count; no wrap is reported.
- Ld=1 (CR=0) -> Q<=D if D<MODULUS, else Q<=MODULUS-1 (clamp). WRP<=0. Load overrides enable.
- Count when CTT&CTP=1 (CR=0, Ld=0):
  - Up: Q<MODULUS-1 -> Q+1. Q==MODULUS-1 -> wrap to 0 (STOP_MODE=0) or hold (STOP_MODE=1).
  - Down: Q>0 -> Q-1. Q==0 -> wrap to MODULUS-1 (STOP_MODE=0) or hold (STOP_MODE=1).
  - WRP<=1 on the edge where Q is at terminal (MODULUS-1 up / 0 down) and counting is enabled, in both modes. Otherwise WRP<=0.
  - In STOP_MODE=1, WRP pulses on every enabled edge while held at terminal. The bench checks this.
- Hold when CTT&CTP=0: Q unchanged, WRP<=0.
- Terminal-count signal: TC = (UD ? Q==MODULUS-1 : Q==0).
- CO = CTT & TC. It is combinational, not gated by CTP, and not gated by CR/Ld.
  - The next stage's CTT is this stage's CO, giving single-cycle synchronous cascade; 74x161 RCO convention.
- A UD change takes effect on the next edge. CO follows UD combinationally in the same cycle.
- Arithmetic is done in WIDTH+1 bits internally. Q never holds a value >= MODULUS.
- Power-up without reset is undefined. Benches assert CR for >=1 edge.

Decomposition:
- Shared package: direction constants (DIR_UP=1, DIR_DOWN=0) and mode constants (MODE_WRAP=0, MODE_STOP=1).
- Shared package: function clog2 for callers sizing WIDTH from MODULUS.
- One flat module; no sub-module is needed.
- A separate top-level cascade wrapper builds the clock from instances (60/60/24). It is not part of this block.

Test Plan:
- WIDTH=6, MODULUS=60, UD=1, CTT=CTP=1 from reset -> Q counts 0..59, then 0. CO=1 only while Q=59. WRP=1 in the cycle after Q=59 -> 0.
- Same config, UD=0, load D=3 -> Q=3,2,1,0,59. CO=1 while Q=0.
- Ld=1 with D=63 (MODULUS=60) -> Q=59. Then count one edge -> Q=0.
- Ld=1 and CTT=CTP=1 simultaneously, D=10 -> Q=10, not 11.
- STOP_MODE=1, MODULUS=10, up from 7 -> Q=8,9,9,9. WRP=1 on each enabled edge after reaching 9.
- Reset mid-operation:
  - At Q=42 assert CR together with Ld=1, D=5 -> Q=RST_VAL (0), WRP=0.
  - CTT=0 -> CO=0 at Q=59.
- Two-stage cascade (60 x 24, stage2 CTT = stage1 CO) -> stage2 increments exactly once per 60 enabled edges. After 1440 edges both stages read 0.

Source files
------------

// File: rtl/mod_n_counter_pkg.sv
// Shared constants and helpers for the modulo-N counter family.
// Callers size WIDTH from MODULUS with clog2 and select direction/mode with these names.
package mod_n_counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int MODE_WRAP = 0;
    localparam int MODE_STOP = 1;

    // Smallest n with 2**n >= value; returns 1 for value <= 2 so a counter is never 0 bits wide.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/mod_n_counter.sv
// Synchronous modulo-N up/down counter with parallel load, wrap/stop mode,
// 74x161-style cascade carry (CO) and a registered wrap pulse (WRP).
module mod_n_counter
    import mod_n_counter_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MODULUS   = 16,
    parameter int STOP_MODE = MODE_WRAP,
    parameter int RST_VAL   = 0
) (
    input  logic             CP,
    input  logic             CR,
    input  logic             Ld,
    input  logic [WIDTH-1:0] D,
    input  logic             CTT,
    input  logic             CTP,
    input  logic             UD,
    output logic [WIDTH-1:0] Q,
    output logic             CO,
    output logic             WRP
);

    generate
        if (WIDTH < 1 || WIDTH > 16 || MODULUS < 2 || MODULUS > (1 << WIDTH) ||
            RST_VAL < 0 || RST_VAL >= MODULUS ||
            (STOP_MODE != MODE_WRAP && STOP_MODE != MODE_STOP)) begin : g_bad_params
            $error("mod_n_counter: illegal WIDTH/MODULUS/STOP_MODE/RST_VAL combination");
        end
    endgenerate

    // One extra bit so MODULUS == 2**WIDTH is representable for the load clamp.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0]   TOP_EXT = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0] TOP_Q   = TOP_EXT[WIDTH-1:0];
    localparam logic [WIDTH-1:0] RST_Q   = WIDTH'(RST_VAL);

    logic [WIDTH:0]   q_ext;
    logic [WIDTH:0]   d_ext;
    logic             tc;
    logic             count_en;
    logic [WIDTH-1:0] q_nxt;
    logic             wrp_nxt;

    assign q_ext    = {1'b0, Q};
    assign d_ext    = {1'b0, D};
    assign count_en = CTT & CTP;
    assign tc       = (UD == DIR_DOWN) ? (q_ext == '0) : (q_ext == TOP_EXT);

    // Carry is deliberately not qualified by CTP, CR or Ld so a cascade settles in one cycle.
    assign CO = CTT & tc;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        q_nxt   = Q;
        wrp_nxt = 1'b0;
        if (Ld) begin
            q_nxt = (d_ext < MOD_EXT) ? D : TOP_Q;
        end else if (count_en) begin
            wrp_nxt = tc;
            if (tc) begin
                if (STOP_MODE == MODE_WRAP) begin
                    q_nxt = (UD == DIR_UP) ? '0 : TOP_Q;
                end
            end else if (UD == DIR_UP) begin
                q_nxt = WIDTH'(q_ext + 1'b1);
            end else begin
                q_nxt = WIDTH'(q_ext - 1'b1);
            end
        end
    end

    always_ff @(posedge CP) begin
        // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
        if (CR) begin
            Q   <= RST_Q;
            WRP <= 1'b0;
        end else begin
            Q   <= q_nxt;
            WRP <= wrp_nxt;
        end
    end

endmodule

// File: tb/tb_mod_n_counter.sv
// Self-checking bench: a wrap-mode 0..59 counter, a stop-mode 0..9 counter and a 60x24 cascade,
// checked against an arithmetic reference model under directed and randomized stimulus.
module tb_mod_n_counter;

    logic       CP;
    bit         cr  [2];
    bit         ld  [2];
    logic [5:0] d   [2];
    bit         ctt [2];
    bit         ctp [2];
    bit         ud  [2];

    logic [5:0] q_a;
    logic [3:0] q_b;
    logic       co_a, co_b, wrp_a, wrp_b;

    int n_checks;
    int n_pass;
    int mq [2];

    mod_n_counter #(.WIDTH(6), .MODULUS(60), .STOP_MODE(0), .RST_VAL(0)) u_wrap (
        .CP(CP), .CR(cr[0]), .Ld(ld[0]), .D(d[0]), .CTT(ctt[0]), .CTP(ctp[0]), .UD(ud[0]),
        .Q(q_a), .CO(co_a), .WRP(wrp_a)
    );

    mod_n_counter #(.WIDTH(4), .MODULUS(10), .STOP_MODE(1), .RST_VAL(0)) u_stop (
        .CP(CP), .CR(cr[1]), .Ld(ld[1]), .D(d[1][3:0]), .CTT(ctt[1]), .CTP(ctp[1]), .UD(ud[1]),
        .Q(q_b), .CO(co_b), .WRP(wrp_b)
    );

    // 60 x 24 cascade: minutes-of-day style chain.
    bit         c_cr, c_en;
    logic [5:0] c_q1;
    logic [4:0] c_q2;
    logic       c_co1, c_co2, c_w1, c_w2;

    mod_n_counter #(.WIDTH(6), .MODULUS(60)) u_s1 (
        .CP(CP), .CR(c_cr), .Ld(1'b0), .D(6'd0), .CTT(c_en), .CTP(1'b1), .UD(1'b1),
        .Q(c_q1), .CO(c_co1), .WRP(c_w1)
    );

    mod_n_counter #(.WIDTH(5), .MODULUS(24)) u_s2 (
        .CP(CP), .CR(c_cr), .Ld(1'b0), .D(5'd0), .CTT(c_co1), .CTP(1'b1), .UD(1'b1),
        .Q(c_q2), .CO(c_co2), .WRP(c_w2)
    );

    initial CP = 1'b0;
    always #5 CP = ~CP;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic int modv(input int k);
        return (k == 0) ? 60 : 10;
    endfunction

    function automatic int get_q(input int k);
        return (k == 0) ? int'(q_a) : int'(q_b);
    endfunction

    function automatic int get_co(input int k);
        return (k == 0) ? int'(co_a) : int'(co_b);
    endfunction

    function automatic int get_wrp(input int k);
        return (k == 0) ? int'(wrp_a) : int'(wrp_b);
    endfunction

    // Reference: counting is modular arithmetic in wrap mode, saturating arithmetic in stop mode.
    function automatic int ref_next_q(input int m, input bit stop, input int q, input bit i_cr,
                                      input bit i_ld, input int i_d, input bit i_ctt,
                                      input bit i_ctp, input bit i_ud);
        if (i_cr) return 0;
        if (i_ld) return (i_d < m) ? i_d : m - 1;
        if (!(i_ctt && i_ctp)) return q;
        if (i_ud) return stop ? ((q + 1 < m) ? q + 1 : m - 1) : (q + 1) % m;
        return stop ? ((q > 0) ? q - 1 : 0) : (q + m - 1) % m;
    endfunction

    function automatic bit ref_wrp(input int m, input int q, input bit i_cr, input bit i_ld,
                                   input bit i_ctt, input bit i_ctp, input bit i_ud);
        if (i_cr || i_ld || !(i_ctt && i_ctp)) return 1'b0;
        return i_ud ? (q == m - 1) : (q == 0);
    endfunction

    // Applies one edge's worth of inputs to instance k, checks CO before the edge and Q/WRP after.
    task automatic step(input int k, input bit i_cr, input bit i_ld, input int i_d,
                        input bit i_ctt, input bit i_ctp, input bit i_ud);
        int m;
        int exp_q;
        bit exp_w;
        m      = modv(k);
        cr[k]  = i_cr;
        ld[k]  = i_ld;
        d[k]   = 6'(i_d);
        ctt[k] = i_ctt;
        ctp[k] = i_ctp;
        ud[k]  = i_ud;
        #1;
        check($sformatf("co%0d q=%0d", k, mq[k]), get_co(k),
              int'(i_ctt && (i_ud ? (mq[k] == m - 1) : (mq[k] == 0))));
        exp_q = ref_next_q(m, k == 1, mq[k], i_cr, i_ld, i_d & ((k == 0) ? 63 : 15),
                           i_ctt, i_ctp, i_ud);
        exp_w = ref_wrp(m, mq[k], i_cr, i_ld, i_ctt, i_ctp, i_ud);
        @(posedge CP);
        #1;
        mq[k] = exp_q;
        check($sformatf("q%0d", k), get_q(k), exp_q);
        check($sformatf("wrp%0d", k), get_wrp(k), int'(exp_w));
        cr[k]  = 1'b0;
        ld[k]  = 1'b0;
        ctt[k] = 1'b0;
        ctp[k] = 1'b0;
    endtask

    initial begin
        int exp_q_tab [5];
        int exp_w_tab [5];
        n_checks = 0;
        n_pass   = 0;
        for (int k = 0; k < 2; k++) begin
            cr[k] = 1'b1; ld[k] = 1'b0; d[k] = '0; ctt[k] = 1'b0; ctp[k] = 1'b0; ud[k] = 1'b1;
        end
        c_cr = 1'b1;
        c_en = 1'b0;
        @(posedge CP);
        #1;
        check("reset_q_a", int'(q_a), 0);
        check("reset_wrp_a", int'(wrp_a), 0);
        check("reset_q_b", int'(q_b), 0);
        check("reset_cascade", int'({c_q2, c_q1}), 0);
        cr[0] = 1'b0;
        cr[1] = 1'b0;
        c_cr  = 1'b0;
        mq[0] = 0;
        mq[1] = 0;

        // Full up cycle 0..59 then wrap.
        for (int i = 0; i < 59; i++) step(0, 0, 0, 0, 1, 1, 1);
        check("up_reach_59", int'(q_a), 59);
        step(0, 0, 0, 0, 1, 1, 1);
        check("up_wrap_q", int'(q_a), 0);
        check("up_wrap_wrp", int'(wrp_a), 1);
        step(0, 0, 0, 0, 1, 1, 1);
        check("wrp_one_cycle", int'(wrp_a), 0);

        // Down from 3 through 0 to 59.
        step(0, 0, 1, 3, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 1, 0);
        check("down_wrap_q", int'(q_a), 59);
        check("down_wrap_wrp", int'(wrp_a), 1);

        // Load clamp then wrap.
        step(0, 0, 1, 63, 0, 0, 1);
        check("clamp_q", int'(q_a), 59);
        step(0, 0, 0, 0, 1, 1, 1);
        check("clamp_then_wrap", int'(q_a), 0);

        // Load beats count.
        step(0, 0, 1, 10, 1, 1, 1);
        check("load_over_count", int'(q_a), 10);

        // Reset beats load mid-count.
        step(0, 0, 1, 42, 0, 0, 1);
        step(0, 1, 1, 5, 1, 1, 1);
        check("reset_over_load_q", int'(q_a), 0);
        check("reset_over_load_wrp", int'(wrp_a), 0);

        // CTT=0 at terminal suppresses CO; CTP=0 does not.
        step(0, 0, 1, 59, 0, 0, 1);
        ctt[0] = 1'b0; ctp[0] = 1'b1; ud[0] = 1'b1;
        #1;
        check("co_gated_by_ctt", int'(co_a), 0);
        ctt[0] = 1'b1; ctp[0] = 1'b0;
        #1;
        check("co_not_gated_by_ctp", int'(co_a), 1);
        ud[0] = 1'b0;
        #1;
        check("co_follows_ud", int'(co_a), 0);
        ctt[0] = 1'b0; ctp[0] = 1'b0;
        @(posedge CP);
        #1;

        // Stop mode: up from 7 saturates at 9 and keeps pulsing WRP.
        exp_q_tab = '{8, 9, 9, 9, 9};
        exp_w_tab = '{0, 0, 1, 1, 1};
        step(1, 0, 1, 7, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 0, 1, 1, 1);
            check($sformatf("stop_up_q[%0d]", i), int'(q_b), exp_q_tab[i]);
            check($sformatf("stop_up_wrp[%0d]", i), int'(wrp_b), exp_w_tab[i]);
        end
        step(1, 0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1, 1, 0);
        check("stop_down_hold", int'(q_b), 0);
        check("stop_down_wrp", int'(wrp_b), 1);
        step(1, 0, 1, 15, 0, 0, 1);
        check("stop_clamp", int'(q_b), 9);

        // Randomized traffic against the model on both instances.
        for (int i = 0; i < 800; i++) begin
            int k;
            k = int'($urandom_range(0, 1));
            step(k, $urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0,
                 int'($urandom_range(0, (k == 0) ? 63 : 15)),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
        end

        // Cascade: stage 2 advances once per 60 enabled edges; 1440 edges return to 0:0.
        c_en = 1'b1;
        for (int n = 1; n <= 1440; n++) begin
            @(posedge CP);
            #1;
            if (n % 60 == 0 || n % 60 == 59) begin
                check($sformatf("cascade_s1 n=%0d", n), int'(c_q1), n % 60);
                check($sformatf("cascade_s2 n=%0d", n), int'(c_q2), (n / 60) % 24);
                check($sformatf("cascade_co1 n=%0d", n), int'(c_co1), int'(n % 60 == 59));
            end
        end
        check("cascade_final_s1", int'(c_q1), 0);
        check("cascade_final_s2", int'(c_q2), 0);
        c_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
